// File: rtl/alu_op_collector_if.sv
// Command, operand and ALU-issue channels of the ALU operand collector.
// Handshake rule: a transfer happens on a rising clk edge where VALID and READY are both high; READY never depends on VALID, and an offer made while READY is low is dropped.
interface alu_op_collector_if #(
  parameter int OP_WIDTH  = 8,
  parameter int CMD_WIDTH = 4
);
  logic                 C_VALID;
  logic                 C_READY;
  logic                 MODE_IN;
  logic [CMD_WIDTH-1:0] CMD_IN;
  logic                 CIN_IN;
  logic                 A_VALID;
  logic                 A_READY;
  logic [OP_WIDTH-1:0]  A_DATA;
  logic                 B_VALID;
  logic                 B_READY;
  logic [OP_WIDTH-1:0]  B_DATA;
  logic [1:0]           INP_VALID;
  logic                 MODE;
  logic [CMD_WIDTH-1:0] CMD;
  logic                 CIN;
  logic [OP_WIDTH-1:0]  OPA;
  logic [OP_WIDTH-1:0]  OPB;
  logic                 ISSUE_STB;
  logic                 TIMEOUT_ERR;

  modport master (
    output C_VALID, MODE_IN, CMD_IN, CIN_IN, A_VALID, A_DATA, B_VALID, B_DATA,
    input  C_READY, A_READY, B_READY, INP_VALID, MODE, CMD, CIN, OPA, OPB,
           ISSUE_STB, TIMEOUT_ERR
  );

  modport slave (
    input  C_VALID, MODE_IN, CMD_IN, CIN_IN, A_VALID, A_DATA, B_VALID, B_DATA,
    output C_READY, A_READY, B_READY, INP_VALID, MODE, CMD, CIN, OPA, OPB,
           ISSUE_STB, TIMEOUT_ERR
  );
endinterface

// File: rtl/alu_op_collector.sv
// Collects an ALU command plus the operands it needs, then issues them to the ALU
// as a one-cycle strobe; a bounded wait issues whatever arrived and flags the timeout.
module alu_op_collector #(
  parameter int OP_WIDTH  = 8,
  parameter int CMD_WIDTH = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              CE,
  alu_op_collector_if.slave bus,
  output logic [1:0]        o_dbg_state
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] { IDLE = 2'd0, COLLECT = 2'd1, ISSUE = 2'd2 } state_t;

  state_t               r_state;
  logic [1:0]           r_need;
  logic [1:0]           r_have;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_mode_cap;
  logic                 r_cin_cap;
  logic [CMD_WIDTH-1:0] r_cmd_cap;
  logic [OP_WIDTH-1:0]  r_opa_cap;
  logic [OP_WIDTH-1:0]  r_opb_cap;
  logic [1:0]           r_inp_valid;
  logic                 r_issue_stb;
  logic                 r_timeout_err;
  logic                 r_mode;
  logic                 r_cin;
  logic [CMD_WIDTH-1:0] r_cmd;
  logic [OP_WIDTH-1:0]  r_opa;
  logic [OP_WIDTH-1:0]  r_opb;

  logic                 w_c_ready;
  logic                 w_a_ready;
  logic                 w_b_ready;
  logic                 w_c_fire;
  logic                 w_a_fire;
  logic                 w_b_fire;
  logic [1:0]           w_need_in;
  logic [1:0]           w_have_next;
  logic [CNT_W-1:0]     w_cnt_next;
  logic [OP_WIDTH-1:0]  w_opa_next;
  logic [OP_WIDTH-1:0]  w_opb_next;
  logic                 w_done;

  function automatic logic [1:0] need_decode(input logic mode, input logic [CMD_WIDTH-1:0] cmd);
    logic [31:0] c;
    logic [1:0]  n;
    c = 32'(cmd);
    n = 2'b00;
    if (mode) begin
      if (c <= 32'd3 || (c >= 32'd8 && c <= 32'd10)) n = 2'b11;
      else if (c <= 32'd5)                          n = 2'b01;
      else if (c <= 32'd7)                          n = 2'b10;
    end else begin
      if (c <= 32'd5 || c == 32'd12 || c == 32'd13)        n = 2'b11;
      else if (c == 32'd6 || c == 32'd8 || c == 32'd9)     n = 2'b01;
      else if (c == 32'd7 || c == 32'd10 || c == 32'd11)   n = 2'b10;
    end
    return n;
  endfunction

  assign w_c_ready   = CE && (r_state == IDLE);
  assign w_a_ready   = CE && (r_state == COLLECT) && r_need[0] && !r_have[0];
  assign w_b_ready   = CE && (r_state == COLLECT) && r_need[1] && !r_have[1];
  assign w_c_fire    = w_c_ready && bus.C_VALID;
  assign w_a_fire    = w_a_ready && bus.A_VALID;
  assign w_b_fire    = w_b_ready && bus.B_VALID;
  assign w_need_in   = need_decode(bus.MODE_IN, bus.CMD_IN);
  assign w_have_next = r_have | {w_b_fire, w_a_fire};
  assign w_opa_next  = w_a_fire ? bus.A_DATA : r_opa_cap;
  assign w_opb_next  = w_b_fire ? bus.B_DATA : r_opb_cap;
  assign w_cnt_next  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
  // A handshake that completes the set on the last allowed cycle wins over the timeout.
  assign w_done      = (w_have_next == r_need) || (w_cnt_next == CNT_MAX);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_state       <= IDLE;
      r_need        <= 2'b00;
      r_have        <= 2'b00;
      r_cnt         <= '0;
      r_mode_cap    <= 1'b0;
      r_cin_cap     <= 1'b0;
      r_cmd_cap     <= '0;
      r_opa_cap     <= '0;
      r_opb_cap     <= '0;
      r_inp_valid   <= 2'b00;
      r_issue_stb   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_mode        <= 1'b0;
      r_cin         <= 1'b0;
      r_cmd         <= '0;
      r_opa         <= '0;
      r_opb         <= '0;
    end else if (CE) begin
      case (r_state)
        IDLE: begin
          if (w_c_fire) begin
            r_mode_cap <= bus.MODE_IN;
            r_cmd_cap  <= bus.CMD_IN;
            r_cin_cap  <= bus.CIN_IN;
            r_need     <= w_need_in;
            r_have     <= 2'b00;
            r_cnt      <= '0;
            // Invalid opcodes skip collection and issue empty the very next cycle.
            if (w_need_in == 2'b00) begin
              r_state       <= ISSUE;
              r_issue_stb   <= 1'b1;
              r_inp_valid   <= 2'b00;
              r_timeout_err <= 1'b0;
              r_mode        <= bus.MODE_IN;
              r_cmd         <= bus.CMD_IN;
              r_cin         <= bus.CIN_IN;
              r_opa         <= '0;
              r_opb         <= '0;
            end else begin
              r_state <= COLLECT;
            end
          end
        end
        COLLECT: begin
          r_have    <= w_have_next;
          r_opa_cap <= w_opa_next;
          r_opb_cap <= w_opb_next;
          r_cnt     <= w_cnt_next;
          if (w_done) begin
            r_state       <= ISSUE;
            r_issue_stb   <= 1'b1;
            r_inp_valid   <= w_have_next;
            r_timeout_err <= (w_have_next != r_need);
            r_mode        <= r_mode_cap;
            r_cmd         <= r_cmd_cap;
            r_cin         <= r_cin_cap;
            r_opa         <= w_have_next[0] ? w_opa_next : '0;
            r_opb         <= w_have_next[1] ? w_opb_next : '0;
          end
        end
        ISSUE: begin
          r_state       <= IDLE;
          r_issue_stb   <= 1'b0;
          r_inp_valid   <= 2'b00;
          r_timeout_err <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // RST gates C_READY so it reads low for the whole time reset is held.
  assign bus.C_READY     = RST && w_c_ready;
  assign bus.A_READY     = w_a_ready;
  assign bus.B_READY     = w_b_ready;
  assign bus.INP_VALID   = r_inp_valid;
  assign bus.ISSUE_STB   = r_issue_stb;
  assign bus.TIMEOUT_ERR = r_timeout_err;
  assign bus.MODE        = r_mode;
  assign bus.CMD         = r_cmd;
  assign bus.CIN         = r_cin;
  assign bus.OPA         = r_opa;
  assign bus.OPB         = r_opb;
  assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_alu_op_collector.sv
// Bench for alu_op_collector: directed scenarios then random transactions, each
// predicted from operand arrival times (in CE-high collect cycles) and the timeout bound.
module tb_alu_op_collector;
  localparam int OPW  = 8;
  localparam int CMDW = 4;
  localparam int TMO  = 16;

  logic       clk;
  logic       rst;
  logic       ce;
  logic [1:0] dbg_state;
  int         n_pass = 0;
  int         n_fail = 0;
  int         n_total = 0;

  alu_op_collector_if #(.OP_WIDTH(OPW), .CMD_WIDTH(CMDW)) bus ();

  alu_op_collector #(.OP_WIDTH(OPW), .CMD_WIDTH(CMDW), .TIMEOUT(TMO)) dut (
    .clk(clk), .RST(rst), .CE(ce), .bus(bus), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference operand-need table.
  function automatic logic [1:0] need_of(input logic m, input logic [3:0] c);
    if (m) begin
      if (c inside {[4'd0:4'd3], [4'd8:4'd10]}) return 2'b11;
      if (c inside {4'd4, 4'd5})               return 2'b01;
      if (c inside {4'd6, 4'd7})               return 2'b10;
      return 2'b00;
    end
    if (c inside {[4'd0:4'd5], 4'd12, 4'd13}) return 2'b11;
    if (c inside {4'd6, 4'd8, 4'd9})         return 2'b01;
    if (c inside {4'd7, 4'd10, 4'd11})       return 2'b10;
    return 2'b00;
  endfunction

  // Driver + model for one transaction. da/db: CE-high collect cycle (1-based) at which
  // A/B start being offered; gap_len CE-low cycles inserted before collect cycle gap_at;
  // hold: CE-low cycles kept while the issue is showing. Entered and left at a negedge, ce=1.
  task automatic run_txn(input logic m, input logic [3:0] c, input logic ci,
                         input logic [7:0] a, input logic [7:0] b,
                         input int da, input int db, input int gap_at, input int gap_len,
                         input int hold);
    logic [1:0] need;
    logic [1:0] have;
    int         k_end;
    int         exp_wall;
    int         wall;
    int         k;
    int         gap_left;
    bit         seen;
    bit         bad_ready;
    need  = need_of(m, c);
    k_end = 0;
    if (need[0] && da > k_end) k_end = da;
    if (need[1] && db > k_end) k_end = db;
    if (k_end > TMO) k_end = TMO;
    have[0]  = need[0] && (da <= k_end);
    have[1]  = need[1] && (db <= k_end);
    exp_wall = k_end + 1 + ((need != 2'b00 && gap_at >= 1 && gap_at <= k_end) ? gap_len : 0);

    check("c_ready_idle", 32'(bus.C_READY), 32'd1);
    bus.C_VALID = 1'b1;
    bus.MODE_IN = m;
    bus.CMD_IN  = c;
    bus.CIN_IN  = ci;
    @(negedge clk);
    bus.C_VALID = 1'b0;
    bus.MODE_IN = ~m;
    bus.CMD_IN  = ~c;
    bus.CIN_IN  = ~ci;
    wall = 1; k = 1; gap_left = gap_len; seen = 1'b0; bad_ready = 1'b0;
    while (!seen && wall <= 80) begin
      if (bus.ISSUE_STB) begin
        seen = 1'b1;
      end else begin
        if (bus.C_READY || (bus.A_READY && !need[0]) || (bus.B_READY && !need[1])) bad_ready = 1'b1;
        if (!ce && (bus.A_READY || bus.B_READY)) bad_ready = 1'b1;
        if (k == gap_at && gap_left > 0) begin
          ce = 1'b0;
          bus.A_VALID = 1'b1; bus.A_DATA = ~a;
          bus.B_VALID = 1'b1; bus.B_DATA = ~b;
          gap_left--;
        end else begin
          ce = 1'b1;
          bus.A_VALID = (k >= da); bus.A_DATA = a;
          bus.B_VALID = (k >= db); bus.B_DATA = b;
          k++;
        end
        @(negedge clk);
        wall++;
      end
    end
    bus.A_VALID = 1'b0;
    bus.B_VALID = 1'b0;
    check("issue_seen",     32'(seen), 32'd1);
    check("issue_cycle",    32'(wall), 32'(exp_wall));
    check("no_stray_ready", 32'(bad_ready), 32'd0);
    check("inp_valid",      32'(bus.INP_VALID), 32'(have));
    check("timeout_err",    32'(bus.TIMEOUT_ERR), 32'(have != need));
    check("opa",            32'(bus.OPA), 32'(have[0] ? a : 8'h00));
    check("opb",            32'(bus.OPB), 32'(have[1] ? b : 8'h00));
    check("mode",           32'(bus.MODE), 32'(m));
    check("cmd",            32'(bus.CMD), 32'(c));
    check("cin",            32'(bus.CIN), 32'(ci));
    for (int i = 0; i < hold; i++) begin
      ce = 1'b0;
      @(negedge clk);
      check("issue_hold_stb", 32'(bus.ISSUE_STB), 32'd1);
      check("issue_hold_inp", 32'(bus.INP_VALID), 32'(have));
    end
    ce = 1'b1;
    @(negedge clk);
    check("stb_clear", 32'(bus.ISSUE_STB), 32'd0);
    check("inp_clear", 32'(bus.INP_VALID), 32'd0);
    check("err_clear", 32'(bus.TIMEOUT_ERR), 32'd0);
    check("opa_hold",  32'(bus.OPA), 32'(have[0] ? a : 8'h00));
  endtask

  initial begin
    logic       rm;
    logic [3:0] rc;
    logic       rci;
    logic [7:0] ra;
    logic [7:0] rb;
    int         rda;
    int         rdb;
    int         rgap;
    int         rlen;

    rst = 1'b0; ce = 1'b1;
    bus.C_VALID = 1'b0; bus.MODE_IN = 1'b0; bus.CMD_IN = '0; bus.CIN_IN = 1'b0;
    bus.A_VALID = 1'b0; bus.A_DATA = '0; bus.B_VALID = 1'b0; bus.B_DATA = '0;
    #1;
    check("rst_c_ready",   32'(bus.C_READY), 32'd0);
    check("rst_a_ready",   32'(bus.A_READY), 32'd0);
    check("rst_issue_stb", 32'(bus.ISSUE_STB), 32'd0);
    check("rst_inp_valid", 32'(bus.INP_VALID), 32'd0);
    check("rst_tmo_err",   32'(bus.TIMEOUT_ERR), 32'd0);
    check("rst_opa",       32'(bus.OPA), 32'd0);
    check("rst_opb",       32'(bus.OPB), 32'd0);
    check("rst_cmd",       32'(bus.CMD), 32'd0);
    check("rst_dbg_state", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("c_ready_after_rst", 32'(bus.C_READY), 32'd1);

    // directed scenarios
    run_txn(1'b1, 4'd0,  1'b0, 8'h12, 8'h34, 1,  1,  0, 0, 0);  // min latency, both operands
    run_txn(1'b0, 4'd6,  1'b1, 8'hF0, 8'h55, 1,  1,  0, 0, 0);  // A-only, B offered but ignored
    run_txn(1'b1, 4'd0,  1'b0, 8'hA1, 8'hB2, 1,  30, 0, 0, 0);  // timeout with A only
    run_txn(1'b1, 4'd0,  1'b1, 8'hA1, 8'hB2, 1,  16, 0, 0, 0);  // B on the last cycle wins
    run_txn(1'b1, 4'd12, 1'b0, 8'h11, 8'h22, 1,  1,  0, 0, 0);  // invalid, mode 1
    run_txn(1'b0, 4'd14, 1'b1, 8'h11, 8'h22, 1,  1,  0, 0, 0);  // invalid, mode 0
    run_txn(1'b1, 4'd0,  1'b0, 8'h3C, 8'hC3, 1,  30, 4, 5, 0);  // CE gap delays timeout
    run_txn(1'b1, 4'd7,  1'b0, 8'h66, 8'h77, 3,  5,  0, 0, 0);  // B-only, late B
    run_txn(1'b0, 4'd3,  1'b1, 8'h9E, 8'h4D, 2,  4,  0, 0, 3);  // ISSUE held with CE low

    // reset in the middle of a collect with A already captured
    check("mid_c_ready", 32'(bus.C_READY), 32'd1);
    bus.C_VALID = 1'b1; bus.MODE_IN = 1'b1; bus.CMD_IN = 4'd0; bus.CIN_IN = 1'b1;
    @(negedge clk);
    bus.C_VALID = 1'b0;
    bus.A_VALID = 1'b1; bus.A_DATA = 8'h5A;
    @(negedge clk);
    bus.A_VALID = 1'b0;
    @(negedge clk);
    check("mid_a_ready_low", 32'(bus.A_READY), 32'd0);
    check("mid_b_ready",     32'(bus.B_READY), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_b_ready", 32'(bus.B_READY), 32'd0);
    check("mid_rst_c_ready", 32'(bus.C_READY), 32'd0);
    check("mid_rst_opa",     32'(bus.OPA), 32'd0);
    check("mid_rst_mode",    32'(bus.MODE), 32'd0);
    check("mid_rst_inp",     32'(bus.INP_VALID), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_no_stb", 32'(bus.ISSUE_STB), 32'd0);
    end
    rst = 1'b1;
    #1;
    check("mid_rel_c_ready", 32'(bus.C_READY), 32'd1);
    run_txn(1'b1, 4'd1, 1'b1, 8'hE7, 8'h18, 1, 2, 0, 0, 0);

    // random transactions
    for (int t = 0; t < 40; t++) begin
      rm  = 1'($urandom_range(0, 1));
      rc  = 4'($urandom_range(0, 15));
      rci = 1'($urandom_range(0, 1));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rda = $urandom_range(1, 20);
      rdb = $urandom_range(1, 20);
      if ($urandom_range(0, 3) == 0) begin
        rgap = $urandom_range(1, 10);
        rlen = $urandom_range(1, 4);
      end else begin
        rgap = 0;
        rlen = 0;
      end
      run_txn(rm, rc, rci, ra, rb, rda, rdb, rgap, rlen, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
